door_lock_ctrl: RTL
===================

Name: door_lock_ctrl

Overview:
Parametrised successor to the single-button motorised door lock. One push-button toggles the lock. The button is debounced, and the motor drive is timed, so each direction runs for a fixed number of cycles. An optional auto-relock timer re-locks an unlocked door. Status outputs are provided for the surrounding system.

Parameters:
DEB_CYCLES, 2, consecutive sampled-high cycles of PRESS required to register a press (>=1)
RUN_CYCLES, 4, cycles the motor output stays asserted per movement (>=1)
RELOCK_CYCLES, 6, cycles spent in UNLOCKED before auto-lock; 0 disables auto-relock
CNT_W, 8, counter width; must satisfy 2**CNT_W > max(DEB_CYCLES, RUN_CYCLES, RELOCK_CYCLES)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-low reset
PRESS  input  1  raw push-button level
M_CW  output  1  motor clockwise (lock drive)
M_ACW  output  1  motor anticlockwise (unlock drive)
LOCKED  output  1  high while in LOCKED state
BUSY  output  1  high while the motor is driven

Behaviour:
- Reset:
  - RST sampled low at a rising edge: state=LOCKED, all counters 0, press arm flag set.
  - Outputs after that edge: M_CW=0, M_ACW=0, LOCKED=1, BUSY=0.
  - Reset mid-movement stops the motor at that same edge.
- Input sampling:
  - PRESS is registered once (p_s).
  - Debounce counter increments on each edge with p_s=1 and clears when p_s=0.
- Press event (press_evt):
  - 1-cycle pulse, raised when the counter reaches DEB_CYCLES while armed; this clears arm.
  - arm re-sets only after p_s=0, so there is one event per physical press.
  - A held button never repeats.
  - A high pulse shorter than DEB_CYCLES cycles produces no event.
- States (one-hot or binary, designer's choice): LOCKED, UNLOCKING, UNLOCKED, LOCKING.
  - LOCKED + press_evt -> UNLOCKING.
  - UNLOCKING -> UNLOCKED after RUN_CYCLES cycles in state.
  - UNLOCKED + (press_evt or relock expiry) -> LOCKING.
  - LOCKING -> LOCKED after RUN_CYCLES cycles in state.
- Run counter:
  - Cleared on motion-state entry; exit occurs on the edge where count == RUN_CYCLES-1.
  - Motor output is therefore high exactly RUN_CYCLES cycles.
- Outputs are Moore decodes of the state register:
  - M_ACW = UNLOCKING; M_CW = LOCKING.
  - BUSY = M_CW | M_ACW; LOCKED = (state==LOCKED).
  - M_CW and M_ACW are never high together.
- Latency:
  - First edge sampling PRESS=1 is edge 0.
  - M_ACW or M_CW rises after edge DEB_CYCLES+1.
- Relock timer:
  - Counts cycles in UNLOCKED and is cleared on entry.
  - Expires when count == RELOCK_CYCLES-1, i.e. after RELOCK_CYCLES cycles in UNLOCKED; the transition happens on that edge.
  - Inactive when RELOCK_CYCLES=0.
- Boundary conditions:
  - press_evt during UNLOCKING/LOCKING is discarded, not queued.
  - press_evt and relock expiry in the same cycle produce a single LOCKING transition.
  - A button held through a whole movement produces no event until it is released and pressed again.
  - Counters saturate-safe: no wrap is possible given the CNT_W constraint.
  - Reset has priority over all events.

Decomposition:
- Shared package door_lock_pkg:
  - state encoding constants (ST_LOCKED, ST_UNLOCKING, ST_UNLOCKED, ST_LOCKING)
  - a function returning the max of the three timing parameters, for CNT_W checking
- One sub-module, press_debounce:
  - contents: input register, debounce counter, arm flag
  - parameters: DEB_CYCLES, CNT_W
  - ports: CLK, RST, PRESS -> press_evt
- door_lock_ctrl holds the FSM, run counter and relock timer.

Test Plan:
(All scenarios use the defaults DEB=2, RUN=4, RELOCK=6 and a 10-unit clock.)
1. Reset: RST=0 for 2 edges with PRESS toggling -> M_CW=0, M_ACW=0, LOCKED=1, BUSY=0 throughout; RST=1 -> still idle.
2. Unlock: PRESS=1 for 3 edges, then 0 -> M_ACW high for exactly 4 cycles starting after edge 3, M_CW=0, BUSY mirrors M_ACW, LOCKED falls after edge 3 and stays 0.
3. Glitch: PRESS=1 for 1 cycle, or 1-0-1-0 at single cycles -> no motor output, LOCKED stays 1.
4. Ignore and hold:
   - Second press during UNLOCKING -> no extra movement.
   - PRESS held high from the start through UNLOCKED -> no LOCKING until PRESS drops and a fresh 3-edge press follows.
5. Auto-relock: after unlock, PRESS=0 -> M_CW high 4 cycles starting 6 cycles after UNLOCKED entry, then LOCKED=1. Repeat with RELOCK_CYCLES=0 -> stays UNLOCKED indefinitely.
6. Reset mid-motion: RST=0 during the 2nd cycle of LOCKING -> M_CW=0 after that edge, LOCKED=1. The next press unlocks normally.

Source files
------------

// File: rtl/door_lock_pkg.sv
// Shared definitions for the motorised door lock: state encodings and a
// helper used to validate counter width against the timing parameters.
package door_lock_pkg;

    localparam logic [1:0] ST_LOCKED    = 2'd0;
    localparam logic [1:0] ST_UNLOCKING = 2'd1;
    localparam logic [1:0] ST_UNLOCKED  = 2'd2;
    localparam logic [1:0] ST_LOCKING   = 2'd3;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/door_lock_ctrl_press_debounce.sv
// Push-button conditioner: registers the raw level, counts consecutive high
// samples and emits a single press event per physical press.
module press_debounce
    import door_lock_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic PRESS,
    output logic press_evt
);

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);

    logic             p_s;
    logic [CNT_W-1:0] deb_cnt;
    logic             arm;

    // Counter saturates at the threshold so a held button cannot wrap around
    // and re-trigger; arm only returns once the button is seen released.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            p_s     <= 1'b0;
            deb_cnt <= '0;
            arm     <= 1'b1;
        end else begin
            p_s <= PRESS;
            if (!p_s) begin
                deb_cnt <= '0;
                arm     <= 1'b1;
            end else begin
                if (deb_cnt != DEB_MAX)
                    deb_cnt <= deb_cnt + 1'b1;
                if (press_evt)
                    arm <= 1'b0;
            end
        end
    end

    assign press_evt = arm && (deb_cnt == DEB_MAX);

endmodule

// File: rtl/door_lock_ctrl.sv
// Single-button motorised door lock: timed lock/unlock drive with optional
// auto-relock after a fixed dwell in the unlocked state.
module door_lock_ctrl
    import door_lock_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 2,
    parameter int unsigned RUN_CYCLES    = 4,
    parameter int unsigned RELOCK_CYCLES = 6,
    parameter int unsigned CNT_W         = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic PRESS,
    output logic M_CW,
    output logic M_ACW,
    output logic LOCKED,
    output logic BUSY
);

    if ((max3(DEB_CYCLES, RUN_CYCLES, RELOCK_CYCLES) >> CNT_W) != 0) begin : g_cnt_w_check
        $error("door_lock_ctrl: CNT_W too small for timing parameters");
    end
    if (DEB_CYCLES == 0 || RUN_CYCLES == 0) begin : g_min_check
        $error("door_lock_ctrl: DEB_CYCLES and RUN_CYCLES must be >= 1");
    end

    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELOCK_LAST =
        CNT_W'((RELOCK_CYCLES == 0) ? 0 : RELOCK_CYCLES - 1);

    logic             press_evt;
    logic [1:0]       state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] relock_cnt;
    logic             relock_exp;

    press_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_press_debounce (
        .CLK       (CLK),
        .RST       (RST),
        .PRESS     (PRESS),
        .press_evt (press_evt)
    );

    assign relock_exp = (state == ST_UNLOCKED) && (RELOCK_CYCLES != 0) &&
                        (relock_cnt == RELOCK_LAST);

    // Press events in the motion states fall through the case untouched,
    // which is what discards them instead of queuing them.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= ST_LOCKED;
            run_cnt    <= '0;
            relock_cnt <= '0;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (press_evt) begin
                        state   <= ST_UNLOCKING;
                        run_cnt <= '0;
                    end
                end
                ST_UNLOCKING: begin
                    if (run_cnt == RUN_LAST) begin
                        state      <= ST_UNLOCKED;
                        relock_cnt <= '0;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                ST_UNLOCKED: begin
                    if (press_evt || relock_exp) begin
                        state   <= ST_LOCKING;
                        run_cnt <= '0;
                    end else if (RELOCK_CYCLES != 0) begin
                        relock_cnt <= relock_cnt + 1'b1;
                    end
                end
                ST_LOCKING: begin
                    if (run_cnt == RUN_LAST)
                        state <= ST_LOCKED;
                    else
                        run_cnt <= run_cnt + 1'b1;
                end
                default: state <= ST_LOCKED;
            endcase
        end
    end

    assign M_ACW  = (state == ST_UNLOCKING);
    assign M_CW   = (state == ST_LOCKING);
    assign BUSY   = M_CW | M_ACW;
    assign LOCKED = (state == ST_LOCKED);

endmodule
